// File: rtl/systolic_pkg.sv
// Shared types and dimensions for the systolic array and its result-drain path.
package systolic_pkg;

  localparam int N     = 14;
  localparam int ACC_W = 32;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_CLR
  } drain_state_t;

endpackage

// File: rtl/drain_out_reg.sv
// Single-entry valid/ready output register carrying one drained accumulator beat.
module drain_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [3:0]   in_row,
  input  logic [3:0]   in_col,
  input  logic         in_last,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic [3:0]   row,
  output logic [3:0]   col,
  output logic         last
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic [3:0]   row_q, row_d;
  logic [3:0]   col_q, col_d;
  logic         last_q, last_d;
  logic         load;

  assign in_ready = !valid_q || ready;
  assign load     = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    row_d   = row_q;
    col_d   = col_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      row_d   = in_row;
      col_d   = in_col;
      last_d  = in_last;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign row   = row_q;
  assign col   = col_q;
  assign last  = last_q;

endmodule

// File: rtl/systolic_acc_drain.sv
// Drains every PE accumulator in row-major order over valid/ready, then pulses
// a one-cycle accumulator clear and done.
module systolic_acc_drain #(
  parameter int N     = systolic_pkg::N,
  parameter int ACC_W = systolic_pkg::ACC_W,
  parameter int RELU  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N*N*ACC_W-1:0]     acc_flat,
  output logic                     busy,
  output logic                     clr_out,
  output logic                     done,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [ACC_W-1:0]  m_data,
  output logic [3:0]               m_row,
  output logic [3:0]               m_col,
  output logic                     m_last
);
  import systolic_pkg::*;

  localparam int NE = N * N;
  localparam int IW = $clog2(NE);

  drain_state_t     state_q, state_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       col_q, col_d;
  logic             remain_q, remain_d;
  logic [IW-1:0]    idx;
  logic [ACC_W-1:0] acc_arr [NE];
  logic [ACC_W-1:0] elem;
  logic [ACC_W-1:0] elem_out;
  logic             ld_valid;
  logic             ld_ready;
  logic             ld;
  logic             last_elem;

  for (genvar g = 0; g < NE; g++) begin : g_acc
    assign acc_arr[g] = acc_flat[g*ACC_W +: ACC_W];
  end

  always_comb begin
    idx       = IW'(row_q) * IW'(N) + IW'(col_q);
    elem      = acc_arr[idx];
    elem_out  = ((RELU != 0) && elem[ACC_W-1]) ? '0 : elem;
    last_elem = (row_q == 4'(N - 1)) && (col_q == 4'(N - 1));
  end

  assign ld_valid = (state_q == S_DRAIN) && remain_q;
  assign ld       = ld_valid && ld_ready;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    remain_d = remain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_DRAIN;
          row_d    = '0;
          col_d    = '0;
          remain_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (ld) begin
          if (last_elem) begin
            // Index parks on the final element; remain_q alone gates further loads.
            remain_d = 1'b0;
          end else if (col_q == 4'(N - 1)) begin
            col_d = '0;
            row_d = row_q + 4'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
        if (!remain_q && m_valid && m_ready && m_last) begin
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      remain_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      remain_q <= remain_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign clr_out = (state_q == S_CLR);
  assign done    = (state_q == S_CLR);

  drain_out_reg #(
    .W (ACC_W)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (ld_valid),
    .in_ready (ld_ready),
    .in_data  (elem_out),
    .in_row   (row_q),
    .in_col   (col_q),
    .in_last  (last_elem),
    .valid    (m_valid),
    .ready    (m_ready),
    .data     (m_data),
    .row      (m_row),
    .col      (m_col),
    .last     (m_last)
  );

endmodule

// File: tb/tb_systolic_acc_drain.sv
// Bench for systolic_acc_drain: beat-level model checked every cycle on a
// pass-through instance and a ReLU instance, plus literal spot checks.
module tb_systolic_acc_drain;

  localparam int N  = 14;
  localparam int NE = N * N;
  localparam int W  = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                m_ready = 1'b1;
  logic [NE*W-1:0]     acc_flat;
  logic signed [W-1:0] acc_v [NE];

  logic busy, clr_out, done, m_valid, m_last;
  logic signed [W-1:0] m_data;
  logic [3:0] m_row, m_col;
  logic r_busy, r_clr_out, r_done, r_m_valid, r_m_last;
  logic signed [W-1:0] r_m_data;
  logic [3:0] r_m_row, r_m_col;

  systolic_acc_drain #(.N(N), .ACC_W(W), .RELU(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_flat(acc_flat),
    .busy(busy), .clr_out(clr_out), .done(done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row(m_row), .m_col(m_col), .m_last(m_last)
  );

  systolic_acc_drain #(.N(N), .ACC_W(W), .RELU(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_flat(acc_flat),
    .busy(r_busy), .clr_out(r_clr_out), .done(r_done),
    .m_valid(r_m_valid), .m_ready(m_ready), .m_data(r_m_data),
    .m_row(r_m_row), .m_col(r_m_col), .m_last(r_m_last)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NE; i++) acc_flat[i*W +: W] = acc_v[i];
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // beat-level model state
  bit active = 1'b0;
  int start_cyc = 0;
  int done_cyc = -1;
  int accepted = 0;

  int beat_cnt, done_cnt, clr_cnt, done_off, stalls;
  logic [W-1:0] cap_d [NE];
  logic [W-1:0] cap_r [NE];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] relu_f(input logic [31:0] v, input bit en);
    return (en && v[31]) ? 32'd0 : v;
  endfunction

  task automatic check_inst(input string t, input bit en,
                            input logic b, input logic d, input logic c, input logic v,
                            input logic [31:0] data, input logic [3:0] row,
                            input logic [3:0] col, input logic last,
                            input bit eb, input bit ed, input bit ev);
    chk({t, ".busy"},    32'(b), 32'(eb));
    chk({t, ".done"},    32'(d), 32'(ed));
    chk({t, ".clr_out"}, 32'(c), 32'(ed));
    chk({t, ".m_valid"}, 32'(v), 32'(ev));
    if (ev) begin
      chk({t, ".m_data"}, data, relu_f(acc_v[accepted], en));
      chk({t, ".m_row"},  32'(row), 32'(accepted / N));
      chk({t, ".m_col"},  32'(col), 32'(accepted % N));
      chk({t, ".m_last"}, 32'(last), 32'(accepted == NE - 1));
    end
  endtask

  always @(negedge clk) begin
    bit eb, ed, ev;
    if (!rst_n) begin
      active   = 1'b0;
      accepted = 0;
      done_cyc = -1;
      check_inst("rst.dut", 1'b0, busy, done, clr_out, m_valid, m_data, m_row, m_col,
                 m_last, 1'b0, 1'b0, 1'b0);
      chk("rst.m_data", m_data, 32'd0);
      chk("rst.m_row",  32'(m_row), 32'd0);
      chk("rst.m_col",  32'(m_col), 32'd0);
      chk("rst.m_last", 32'(m_last), 32'd0);
    end else begin
      eb = active;
      ev = active && (cyc >= start_cyc + 2) && (accepted < NE);
      ed = active && (cyc == done_cyc);
      check_inst("dut", 1'b0, busy, done, clr_out, m_valid, m_data, m_row, m_col,
                 m_last, eb, ed, ev);
      check_inst("relu", 1'b1, r_busy, r_done, r_clr_out, r_m_valid, r_m_data, r_m_row,
                 r_m_col, r_m_last, eb, ed, ev);
      if (m_valid && m_ready) beat_cnt++;
      if (done) begin
        done_cnt++;
        done_off = cyc - start_cyc;
      end
      if (clr_out) clr_cnt++;
      if (ev && !m_ready) stalls++;
      if (ev && m_ready) begin
        cap_d[accepted] = m_data;
        cap_r[accepted] = r_m_data;
        accepted++;
        if (accepted == NE) done_cyc = cyc + 1;
      end
      if (active && cyc == done_cyc) begin
        active = 1'b0;
      end else if (!active && start) begin
        active    = 1'b1;
        start_cyc = cyc;
        accepted  = 0;
        done_cyc  = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_counts();
    beat_cnt = 0;
    done_cnt = 0;
    clr_cnt  = 0;
    done_off = -1;
    stalls   = 0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    for (int k = 0; k < budget; k++) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      tick();
      if (!active) break;
    end
    chk("drain_timeout", 32'(active), 32'd0);
    m_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < NE; i++) acc_v[i] = (i / N) * 100 + (i % N);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    fill_pattern();
    clear_counts();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset.busy",    32'(busy),    32'd0);
    chk("reset.m_valid", 32'(m_valid), 32'd0);
    chk("reset.m_data",  m_data,       32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // basic drain
    clear_counts();
    pulse_start();
    wait_idle(400, 1'b0);
    chk("basic.first",    cap_d[0],   32'd0);
    chk("basic.beat15",   cap_d[15],  32'd101);
    chk("basic.last",     cap_d[195], 32'd1313);
    chk("basic.done_off", 32'(done_off), 32'd198);
    chk("basic.beats",    32'(beat_cnt), 32'd196);
    chk("basic.dones",    32'(done_cnt), 32'd1);

    // backpressure with random data
    for (int i = 0; i < NE; i++) acc_v[i] = $urandom;
    clear_counts();
    pulse_start();
    wait_idle(2000, 1'b1);
    chk("bp.done_off", 32'(done_off), 32'(198 + stalls));
    chk("bp.beats",    32'(beat_cnt), 32'd196);
    chk("bp.dones",    32'(done_cnt), 32'd1);

    // ReLU corner values
    fill_pattern();
    acc_v[3*N+4] = -5;
    acc_v[3*N+5] = 32'h7FFF_FFFF;
    clear_counts();
    pulse_start();
    wait_idle(400, 1'b0);
    chk("relu.neg",    cap_r[3*N+4], 32'd0);
    chk("relu.max",    cap_r[3*N+5], 32'h7FFF_FFFF);
    chk("norelu.neg",  cap_d[3*N+4], 32'hFFFF_FFFB);

    // spurious starts at beat 10, beat 195 and during the clear cycle
    fill_pattern();
    clear_counts();
    pulse_start();
    repeat (11) tick();
    pulse_start();
    repeat (184) tick();
    pulse_start();
    pulse_start();
    wait_idle(400, 1'b0);
    chk("spur.beats", 32'(beat_cnt), 32'd196);
    chk("spur.dones", 32'(done_cnt), 32'd1);

    // back-to-back: second start the cycle busy falls
    clear_counts();
    pulse_start();
    repeat (198) tick();
    pulse_start();
    wait_idle(400, 1'b0);
    chk("b2b.clrs",     32'(clr_cnt),  32'd2);
    chk("b2b.beats",    32'(beat_cnt), 32'd392);
    chk("b2b.done_off", 32'(done_off), 32'd198);

    // reset during beat 50, then a clean drain
    clear_counts();
    pulse_start();
    repeat (51) tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid.m_valid", 32'(m_valid), 32'd0);
    chk("rstmid.busy",    32'(busy),    32'd0);
    chk("rstmid.m_row",   32'(m_row),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    clear_counts();
    pulse_start();
    wait_idle(400, 1'b0);
    chk("rstmid.dones", 32'(done_cnt), 32'd1);
    chk("rstmid.beats", 32'(beat_cnt), 32'd196);
    chk("rstmid.first", cap_d[0],      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
